cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Blocking read controller for the direct-mapped instruction/data cache.
- Sequences the CPU-side lookup, detects hit or miss, fetches a 4-word block from dataMem over a req/ack handshake on a miss, fills the line, and returns the requested word.
- Owns the tag, valid and data line store. Sits between the CPU read port and the block-wide memory port.

Parameters:
- ADDR_W, 15, word address width.
- WORD_W, 32, data word width.
- INDEX_W, 10, line index width (1024 lines).
- OFFSET_W, 2, word-in-block offset width (4 words/block, fixed).
- Derived: TAG_W = ADDR_W - INDEX_W - OFFSET_W (3 by default).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  read request valid.
- cpu_addr  in  ADDR_W  word address; sampled when cpu_req && cpu_ready.
- cpu_ready  out  1  controller can accept a request (IDLE only).
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  WORD_W  requested word.
- mem_req  out  1  block fetch request; held until mem_ack.
- mem_addr  out  ADDR_W-OFFSET_W  block address = addr[14:2].
- mem_ack  in  1  block data valid this cycle.
- mem_rdata  in  4*WORD_W  block; word k at bits [32k+31:32k].

Behaviour:
- Address split: offset = addr[1:0], index = addr[11:2], tag = addr[14:12].
- Reset (rst low, any state): state goes to IDLE and all valid bits clear. Outputs: cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_addr=0. Tag and data arrays are not reset.
- FSM states: IDLE, LOOKUP, FETCH, RESPOND.
  - IDLE: cpu_ready=1. On cpu_req, latch the address and go to LOOKUP.
  - LOOKUP: cpu_ready=0. Hit = valid[index] && tag_store[index]==tag.
    - Hit: go to RESPOND.
    - Miss: go to FETCH and assert mem_req with mem_addr from the next cycle.
  - FETCH: mem_req=1 and mem_addr stable until mem_ack is sampled high.
    - On mem_ack: write the block to data[index], write tag, set valid, register the requested word from mem_rdata, go to RESPOND.
    - mem_req deasserts in the cycle after ack.
  - RESPOND: cpu_rvalid=1 for exactly one cycle with cpu_rdata. Next state is IDLE. cpu_ready returns next cycle.
- Latency from the accept edge:
  - Hit: cpu_rvalid 2 cycles later.
  - Miss: cpu_rvalid 1 cycle after the mem_ack sample.
  - Minimum miss latency: 3 cycles if mem_ack is high on the first FETCH cycle.
- cpu_rdata holds its last value outside RESPOND.
- Boundary conditions:
  - cpu_req while busy: ignored, not queued. The requester must hold cpu_req until it sees cpu_ready.
  - mem_ack outside FETCH: ignored, no array write.
  - Conflict miss (same index, different tag): the line is overwritten unconditionally. Read-only cache, no writeback.
  - Address 0 and 0x7FFF map to index 0/tag 0 and index 1023/tag 7. No wrap hazards.
  - Reset during FETCH: mem_req drops immediately (async). A late mem_ack is ignored.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Defined: adds output ports hit_count[15:0] and miss_count[15:0].
  - Counters are cleared by rst.
  - They increment in LOOKUP on hit or miss respectively and saturate at 0xFFFF.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W, WORD_W, INDEX_W, OFFSET_W, TAG_W constants.
  - typedef state_t enum {IDLE, LOOKUP, FETCH, RESPOND}.
  - typedef block_t: logic [3:0][WORD_W-1:0].
  - Address field extraction functions get_tag, get_index, get_offset.
- One sub-module, cache_line_store: tag/valid/data arrays.
  - Combinational read by index.
  - Synchronous write on fill.
  - Async valid clear on rst.
- cache_controller contains the FSM, hit logic and word select.

Test Plan:
- Cold read: reset, then request addr 24; memory acks after 3 cycles with block {d27,d26,d25,d24} → one mem_req with mem_addr=6, cpu_rdata=d24, cpu_rvalid 6 cycles after accept.
- Same-block hits: after the above, addrs 25, 26, 27 → no mem_req; cpu_rdata = d25, d26, d27, each with 2-cycle latency.
- New block then reuse: addr 28 → miss with mem_addr=7; then addr 24 → hit returning d24, with no mem_req.
- Conflict: addr 4120 (index 6, tag 1) → miss with mem_addr=1030 and new data; then addr 24 → miss again.
- Reset mid-fetch: drive rst low during FETCH, then ack → mem_req=0 immediately, no rvalid. A rerequest of 24 misses (valid cleared).
- Busy and back-pressure: hold cpu_req with a new address during FETCH → cpu_ready=0, request not accepted until after RESPOND. With CACHE_PERF_CNT_EN, counters after the full sequence match the expected hit/miss totals.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants, types and address helpers for the read cache
//
// Address layout (word address): [14:12] tag, [11:2] index, [1:0] word offset.
package cache_pkg;

    localparam int ADDR_W     = 15;
    localparam int WORD_W     = 32;
    localparam int INDEX_W    = 10;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FETCH,
        RESPOND
    } state_t;

    typedef logic [3:0][WORD_W-1:0] block_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag/valid/data arrays of the direct-mapped cache
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears valid bits only)
//   rd_index          line to look up; rd_valid/rd_tag/rd_block are combinational
//   wr_en             fill strobe; writes wr_tag/wr_block to wr_index and sets valid
module cache_line_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output block_t             rd_block,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  block_t             wr_block
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    block_t           data_mem [LINES];

    // Only the valid bits are reset; stale tags/data behind a clear valid
    // bit can never produce a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_block;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_block = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - blocking read controller for the direct-mapped cache
//
// Optional feature macro: CACHE_PERF_CNT_EN (adds saturating hit_count/miss_count).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cpu_req/cpu_addr         read request, accepted when cpu_ready is high (IDLE)
//   cpu_ready                controller idle and able to accept
//   cpu_rvalid/cpu_rdata     one-cycle response; cpu_rdata holds between responses
//   mem_req/mem_addr         block fetch request, held until mem_ack
//   mem_ack/mem_rdata        block returned; word k at bits [32k+31:32k]
//   hit_count/miss_count     lookup statistics (CACHE_PERF_CNT_EN only)
module cache_controller
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_W-1:0]     cpu_addr,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic                  mem_req,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  block_t                mem_rdata
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] rdata_q;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    block_t            rd_block;
    logic              hit;
    logic              fill;

    cache_line_store u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (get_index(addr_q)),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_block (rd_block),
        .wr_en    (fill),
        .wr_index (get_index(addr_q)),
        .wr_tag   (get_tag(addr_q)),
        .wr_block (mem_rdata)
    );

    assign hit  = rd_valid && (rd_tag == get_tag(addr_q));
    // mem_ack is only meaningful while a fetch is outstanding.
    assign fill = (state == FETCH) && mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_q <= cpu_addr;
            end
            if (state == LOOKUP && hit) begin
                rdata_q <= rd_block[get_offset(addr_q)];
            end else if (fill) begin
                // Forward the word straight from the bus rather than re-reading the line.
                rdata_q <= mem_rdata[get_offset(addr_q)];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = hit ? RESPOND : FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                cpu_rvalid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign mem_addr  = mem_req ? addr_q[ADDR_W-1:OFFSET_W] : '0;

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
